uart_rx_sequencer: RTL
======================

Name: uart_rx_sequencer

Overview:
Control FSM for the UART receive datapath (SIPO shift register plus 4-bit bit counter). It synchronises the raw rx pin and times each bit with an internal baud counter, sampling at mid-bit. It validates the start bit, strobes the shift register once per data bit, and checks the stop bit. It reports either a received byte (rx_valid) or a framing error to the uart top level. Frame format is 8N1 by default.

Parameters:
CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200); must be >= 4.
DATA_BITS, 8, data bits per frame; must be 1..15 to fit the 4-bit rx_count.

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
rx  input  1  raw UART RX pin (asynchronous); idle high
rx_count  input  4  bit counter value returned by the datapath
rx_en  output  1  shift-register enable; 1-cycle pulse per data bit
rx_rst  output  1  shift-register reset; 1-cycle pulse
rx_count_up  output  1  bit counter increment; 1-cycle pulse
rx_count_clr  output  1  bit counter clear; 1-cycle pulse
rx_valid  output  1  byte complete, rx_data good; 1-cycle pulse
frame_err  output  1  stop bit sampled low; 1-cycle pulse
busy  output  1  high in any state other than IDLE

Behaviour:
- Synchroniser: 2-flop chain on rx produces rx_s (2-cycle latency). Both flops reset to 1. All decisions below use rx_s only.
- Baud counter: width clog2(CLKS_PER_BIT). Cleared on every state transition. Otherwise increments every cycle outside IDLE.
- HALF = CLKS_PER_BIT/2 (integer division). FULL = CLKS_PER_BIT-1.
- Reset: state = IDLE, baud counter = 0. All pulse outputs and busy = 0.
- The control outputs (rx_en, rx_rst, rx_count_up, rx_count_clr) are combinational decodes of state and baud counter, so the datapath acts at the same clock edge. rx_valid and frame_err are registered, i.e. asserted the cycle after the decision.
- IDLE: when rx_s == 0, go to START and pulse rx_count_clr and rx_rst in that same cycle.
- START: when baud == HALF-1, sample rx_s.
  - rx_s == 0: go to DATA.
  - rx_s == 1: glitch/false start; go to IDLE with no outputs.
- DATA: when baud == FULL (mid-bit, one full period after the previous sample), pulse rx_en and rx_count_up.
  - If rx_count == DATA_BITS-1 (pre-increment value), go to STOP; otherwise stay in DATA.
- STOP: when baud == FULL, sample rx_s.
  - rx_s == 1: next cycle rx_valid = 1; go to IDLE.
  - rx_s == 0: next cycle frame_err = 1; go to BREAK.
- BREAK: wait until rx_s == 1, then go to IDLE. A held-low line must not be taken as a new start bit.
- rx_valid and frame_err are mutually exclusive and each fires at most once per frame.
- rx_data stays stable from the rx_valid pulse until the rx_rst pulse of the next start bit.
- Back-to-back frames: a start edge seen in the cycle after the return to IDLE is accepted. The minimum gap is zero idle bits beyond the stop bit.
- Reset asserted mid-frame: abort at the next edge to IDLE. No rx_valid or frame_err is emitted. The synchroniser is reinitialised to 1.
- busy = (state != IDLE), so busy is high in BREAK.

Test Plan:
Use CLKS_PER_BIT=16 and DATA_BITS=8 for all scenarios.
1. Frame for byte 0xA5, LSB first, stop=1 -> exactly 8 rx_en pulses spaced 16 cycles apart, the first 8+16 cycles after the synchronised start edge. rx_valid pulses once, frame_err stays 0, datapath rx_data = 0xA5.
2. rx low for 5 cycles, then high (glitch shorter than HALF) -> return to IDLE. No rx_en, rx_valid or frame_err. rx_count_clr/rx_rst pulse once; busy is high for about 8 cycles.
3. Byte 0x3C with stop bit = 0, line held low for 40 cycles afterwards -> frame_err pulses once, no rx_valid. State stays BREAK (busy=1) until rx_s returns high. No new frame starts during the low period.
4. Bytes 0x00 then 0xFF back-to-back with no idle gap -> two rx_valid pulses, 160 cycles apart. Captured values are 0x00 then 0xFF.
5. Reset asserted during DATA bit 4 of a frame -> all outputs 0 the next cycle, state IDLE, no rx_valid. A following clean 0x5A frame is received correctly.
6. Frame with rx_count forced to 7 in the datapath at bit 2 -> the FSM enters STOP after the current rx_en. This confirms the exit condition uses the rx_count input rather than an internal count.

Source files
------------

// File: rtl/uart_rx_sequencer.sv
// Receive-side control FSM for the UART: synchronises rx, times bits with a
// baud counter and drives the SIPO shift register / bit counter datapath.
module uart_rx_sequencer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       rx_i,
  input  logic [3:0] rx_count_i,
  output logic       rx_en_o,
  output logic       rx_rst_o,
  output logic       rx_count_up_o,
  output logic       rx_count_clr_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] HALF_M1  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL     = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic              rx_meta_q, rx_s_q;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              baud_half, baud_full;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign baud_half = (baud_q == HALF_M1);
  assign baud_full = (baud_q == FULL);

  always_comb begin
    state_d        = state_q;
    valid_d        = 1'b0;
    ferr_d         = 1'b0;
    rx_en_o        = 1'b0;
    rx_count_up_o  = 1'b0;
    rx_rst_o       = 1'b0;
    rx_count_clr_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d        = START;
          rx_rst_o       = 1'b1;
          rx_count_clr_o = 1'b1;
        end
      end
      START: begin
        if (baud_half) begin
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_full) begin
          rx_en_o       = 1'b1;
          rx_count_up_o = 1'b1;
          // Exit is decided by the datapath's count, not a private copy.
          if (rx_count_i == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (baud_full) begin
          if (rx_s_q) begin
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Wrapping at FULL keeps consecutive data samples exactly one bit apart
  // even when CLKS_PER_BIT is not a power of two.
  always_comb begin
    baud_d = baud_q + BAUD_W'(1);
    if ((state_d != state_q) || (state_q == IDLE) || baud_full) begin
      baud_d = '0;
    end
  end

  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != IDLE);

endmodule
